// File: rtl/arty_btn_debounce.sv
// Conditions the raw Arty push-buttons for the system PIO button input and its IRQ.
// Per button: 2-FF synchronizer, saturating-window debounce counter and registered
// press/release pulses. Sticky press events (write-1-to-clear, set wins) are
// masked into a single registered level interrupt. Everything lives in clk_riscv.
//
// Ports
//   clk          system clock (clk_riscv)
//   rst          synchronous reset, active-high
//   btn_in       raw button pads, asynchronous, 1 = pressed
//   irq_mask     1 = press event of that button may raise irq
//   evt_clr      single-cycle write-1-to-clear strobe for evt_status bits
//   btn_stable   debounced level, 1 = pressed
//   btn_press    one-cycle pulse on debounced 0->1
//   btn_release  one-cycle pulse on debounced 1->0
//   evt_status   sticky press-event flags
//   irq          registered |(evt_status & irq_mask)
module arty_btn_debounce #(
    parameter int unsigned BTN_NUM   = 4,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_NUM-1:0] btn_in,
    input  logic [BTN_NUM-1:0] irq_mask,
    input  logic [BTN_NUM-1:0] evt_clr,
    output logic [BTN_NUM-1:0] btn_stable,
    output logic [BTN_NUM-1:0] btn_press,
    output logic [BTN_NUM-1:0] btn_release,
    output logic [BTN_NUM-1:0] evt_status,
    output logic               irq
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    // Last count value before a differing level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [BTN_NUM-1:0] sync1_q, sync2_q;
    logic [BTN_NUM-1:0] stable_q, stable_d;
    logic [BTN_NUM-1:0] press_q, press_d;
    logic [BTN_NUM-1:0] release_q, release_d;
    logic [BTN_NUM-1:0] evt_q, evt_d;
    logic               irq_q, irq_d;
    logic [CNT_W-1:0]   cnt_q [BTN_NUM];
    logic [CNT_W-1:0]   cnt_d [BTN_NUM];

    // Debounce window, edge pulses, sticky events and interrupt.
    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(BTN_NUM); i++) begin
            cnt_d[i] = '0;
            // Matching level (or a glitch back to it) restarts the window.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i]  = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Set has priority over clear so a press is never lost.
        evt_d = (evt_q & ~evt_clr) | press_d;
        irq_d = |(evt_q & irq_mask);
    end

    // State registers; btn_in only ever reaches logic through sync2_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            evt_q     <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < int'(BTN_NUM); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            evt_q     <= evt_d;
            irq_q     <= irq_d;
            for (int i = 0; i < int'(BTN_NUM); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_stable  = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign evt_status  = evt_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_arty_btn_debounce.sv
// Bench for arty_btn_debounce with DB_CYCLES=8 (accept latency 10 edges).
// Expectations are queued with the edge they are due at and checked 1 time unit
// after that edge.
module tb_arty_btn_debounce;

    localparam int unsigned BTN_NUM = 4;
    localparam int unsigned DB      = 8;
    localparam int unsigned LAT     = DB + 2;

    localparam int unsigned F_STB = 0;
    localparam int unsigned F_PRS = 1;
    localparam int unsigned F_REL = 2;
    localparam int unsigned F_EVT = 3;
    localparam int unsigned F_IRQ = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [BTN_NUM-1:0] btn_in;
    logic [BTN_NUM-1:0] irq_mask;
    logic [BTN_NUM-1:0] evt_clr;
    logic [BTN_NUM-1:0] btn_stable;
    logic [BTN_NUM-1:0] btn_press;
    logic [BTN_NUM-1:0] btn_release;
    logic [BTN_NUM-1:0] evt_status;
    logic               irq;

    always #5 clk = ~clk;

    arty_btn_debounce #(
        .BTN_NUM   (BTN_NUM),
        .DB_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .irq_mask    (irq_mask),
        .evt_clr     (evt_clr),
        .btn_stable  (btn_stable),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .evt_status  (evt_status),
        .irq         (irq)
    );

    typedef struct {
        int unsigned due;
        int unsigned sel;
        logic [3:0]  exp;
        string       name;
    } sb_t;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] mask;
        logic [3:0] stb;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] evt;
        logic       irq_pre;
        logic       irq_post;
    } row_t;

    sb_t         sbq[$];
    row_t        rows[6];
    int unsigned cyc   = 0;
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    function automatic logic [3:0] field(input int unsigned sel);
        case (sel)
            F_STB:   return btn_stable;
            F_PRS:   return btn_press;
            F_REL:   return btn_release;
            F_EVT:   return evt_status;
            default: return {3'b000, irq};
        endcase
    endfunction

    task automatic expect_out(input int unsigned dly, input int unsigned sel,
                              input logic [3:0] exp, input string name);
        sb_t e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    // One clock edge, then retire every expectation due at this edge.
    task automatic step();
        int k;
        logic [3:0] act;
        @(posedge clk);
        #1;
        cyc++;
        k = 0;
        while (k < sbq.size()) begin
            if (sbq[k].due <= cyc) begin
                act = field(sbq[k].sel);
                n_chk++;
                if (sbq[k].due < cyc || act !== sbq[k].exp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d due=%0d got=%h want=%h",
                             sbq[k].name, cyc, sbq[k].due, act, sbq[k].exp);
                end
                sbq.delete(k);
            end else begin
                k++;
            end
        end
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic clear_evt(input logic [3:0] bits);
        evt_clr = bits;
        expect_out(1, F_EVT, 4'h0, "evt_clear");
        step();
        evt_clr = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            btn    mask   stb    prs    rel    evt    pre   post
        rows[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0};
        rows[1] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 1'b1};
        rows[2] = '{4'h3, 4'h1, 4'h3, 4'h2, 4'h0, 4'h3, 1'b1, 1'b1};
        rows[3] = '{4'h6, 4'h1, 4'h6, 4'h4, 4'h1, 4'h7, 1'b1, 1'b1};
        rows[4] = '{4'h9, 4'h8, 4'h9, 4'h9, 4'h6, 4'hF, 1'b0, 1'b1};
        rows[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'hF, 1'b0, 1'b0};

        // Reset with all buttons held.
        rst      = 1'b1;
        btn_in   = 4'hF;
        irq_mask = 4'h0;
        evt_clr  = 4'h0;
        for (int r = 0; r < 2; r++) begin
            expect_out(1, F_STB, 4'h0, "rst_stable");
            expect_out(1, F_PRS, 4'h0, "rst_press");
            expect_out(1, F_REL, 4'h0, "rst_release");
            expect_out(1, F_EVT, 4'h0, "rst_evt");
            expect_out(1, F_IRQ, 4'h0, "rst_irq");
            step();
        end
        rst = 1'b0;
        for (int d = 1; d < int'(LAT); d++) begin
            expect_out(d, F_STB, 4'h0, "held_stable_early");
            expect_out(d, F_PRS, 4'h0, "held_press_early");
        end
        expect_out(LAT,     F_STB, 4'hF, "held_stable");
        expect_out(LAT,     F_PRS, 4'hF, "held_press");
        expect_out(LAT,     F_EVT, 4'hF, "held_evt");
        expect_out(LAT + 1, F_PRS, 4'h0, "held_press_end");
        expect_out(LAT + 1, F_IRQ, 4'h0, "held_irq_masked");
        run(LAT + 1);
        clear_evt(4'hF);

        // Table of clean level steps, one settle window each.
        for (int r = 0; r < 6; r++) begin
            logic [3:0] prev;
            prev     = (r == 0) ? 4'hF : rows[r-1].stb;
            btn_in   = rows[r].btn;
            irq_mask = rows[r].mask;
            expect_out(LAT - 1, F_STB, prev,                     $sformatf("row%0d_stb_pre", r));
            expect_out(LAT,     F_STB, rows[r].stb,              $sformatf("row%0d_stb", r));
            expect_out(LAT,     F_PRS, rows[r].prs,              $sformatf("row%0d_press", r));
            expect_out(LAT,     F_REL, rows[r].rel,              $sformatf("row%0d_release", r));
            expect_out(LAT,     F_EVT, rows[r].evt,              $sformatf("row%0d_evt", r));
            expect_out(LAT,     F_IRQ, {3'b000, rows[r].irq_pre},  $sformatf("row%0d_irq_lag", r));
            expect_out(LAT + 1, F_IRQ, {3'b000, rows[r].irq_post}, $sformatf("row%0d_irq", r));
            expect_out(LAT + 1, F_PRS, 4'h0,                     $sformatf("row%0d_press_end", r));
            expect_out(LAT + 1, F_REL, 4'h0,                     $sformatf("row%0d_release_end", r));
            run(LAT + 2);
        end
        clear_evt(4'hF);

        // Bounce on bit 1, then a clean hold.
        for (int t = 0; t < 40; t++) begin
            btn_in[1] = ((t / 3) % 2) == 0;
            expect_out(1, F_PRS, 4'h0, "bounce_press");
            expect_out(1, F_STB, 4'h0, "bounce_stable");
            step();
        end
        btn_in[1] = 1'b1;
        for (int d = 1; d < int'(LAT); d++) begin
            expect_out(d, F_PRS, 4'h0, "bounce_tail_press");
        end
        expect_out(LAT,     F_STB, 4'h2, "bounce_stable_final");
        expect_out(LAT,     F_PRS, 4'h2, "bounce_press_final");
        expect_out(LAT,     F_EVT, 4'h2, "bounce_evt");
        expect_out(LAT + 1, F_PRS, 4'h0, "bounce_press_end");
        run(LAT + 1);
        btn_in[1] = 1'b0;
        expect_out(LAT, F_REL, 4'h2, "bounce_release");
        expect_out(LAT, F_STB, 4'h0, "bounce_released");
        run(LAT + 1);
        clear_evt(4'h2);

        // Pulse of DB-1 cycles on bit 2 must be rejected.
        btn_in[2] = 1'b1;
        for (int d = 0; d < int'(DB) - 1; d++) begin
            expect_out(1, F_STB, 4'h0, "glitch7_stable");
            step();
        end
        btn_in[2] = 1'b0;
        for (int d = 0; d < 12; d++) begin
            expect_out(1, F_STB, 4'h0, "glitch7_stable_after");
            expect_out(1, F_PRS, 4'h0, "glitch7_press");
            expect_out(1, F_REL, 4'h0, "glitch7_release");
            expect_out(1, F_EVT, 4'h0, "glitch7_evt");
            step();
        end

        // Pulse of exactly DB cycles on bit 2 is accepted.
        btn_in[2] = 1'b1;
        for (int d = 0; d < int'(DB); d++) begin
            expect_out(1, F_PRS, 4'h0, "pulse8_press_early");
            step();
        end
        btn_in[2] = 1'b0;
        expect_out(1,  F_STB, 4'h0, "pulse8_stable_pre");
        expect_out(2,  F_STB, 4'h4, "pulse8_stable");
        expect_out(2,  F_PRS, 4'h4, "pulse8_press");
        expect_out(2,  F_EVT, 4'h4, "pulse8_evt");
        expect_out(3,  F_PRS, 4'h0, "pulse8_press_end");
        expect_out(9,  F_STB, 4'h4, "pulse8_hold");
        expect_out(10, F_STB, 4'h0, "pulse8_stable_rel");
        expect_out(10, F_REL, 4'h4, "pulse8_release");
        run(11);
        clear_evt(4'h4);

        // Clear strobe on the acceptance edge of bit 3: set wins.
        irq_mask  = 4'h8;
        btn_in[3] = 1'b1;
        run(LAT - 1);
        evt_clr = 4'h8;
        expect_out(1, F_EVT, 4'h8, "race_evt_set_wins");
        expect_out(1, F_PRS, 4'h8, "race_press");
        expect_out(1, F_IRQ, 4'h0, "race_irq_lag");
        step();
        expect_out(1, F_EVT, 4'h0, "race_evt_cleared");
        expect_out(1, F_IRQ, 4'h1, "race_irq_high");
        step();
        evt_clr = 4'h0;
        expect_out(1, F_IRQ, 4'h0, "race_irq_drop");
        step();
        btn_in[3] = 1'b0;
        expect_out(LAT, F_REL, 4'h8, "race_release");
        expect_out(LAT, F_EVT, 4'h0, "race_release_no_evt");
        run(LAT + 1);

        // Masked press, later unmask, release keeps the event.
        irq_mask  = 4'h0;
        btn_in[0] = 1'b1;
        expect_out(LAT,     F_EVT, 4'h1, "mask_evt");
        expect_out(LAT,     F_PRS, 4'h1, "mask_press");
        expect_out(LAT + 1, F_IRQ, 4'h0, "mask_irq_low");
        expect_out(LAT + 2, F_IRQ, 4'h0, "mask_irq_low2");
        run(LAT + 2);
        irq_mask = 4'h1;
        expect_out(1, F_IRQ, 4'h1, "unmask_irq");
        step();
        btn_in[0] = 1'b0;
        expect_out(LAT, F_REL, 4'h1, "mask_release");
        expect_out(LAT, F_EVT, 4'h1, "mask_release_evt");
        expect_out(LAT, F_IRQ, 4'h1, "mask_release_irq");
        run(LAT);
        irq_mask = 4'h0;
        expect_out(1, F_IRQ, 4'h0, "remask_irq");
        expect_out(1, F_EVT, 4'h1, "remask_evt_kept");
        step();
        clear_evt(4'h1);

        // Reset in the middle of a debounce window.
        btn_in[0] = 1'b1;
        run(5);
        rst = 1'b1;
        expect_out(1, F_STB, 4'h0, "midrst_stable");
        expect_out(1, F_PRS, 4'h0, "midrst_press");
        step();
        rst = 1'b0;
        for (int d = 1; d < int'(LAT); d++) begin
            expect_out(d, F_STB, 4'h0, "midrst_stable_wait");
        end
        expect_out(LAT,     F_STB, 4'h1, "midrst_stable_final");
        expect_out(LAT,     F_PRS, 4'h1, "midrst_press_final");
        expect_out(LAT + 1, F_PRS, 4'h0, "midrst_press_end");
        run(LAT + 1);

        while (sbq.size() > 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL %s cyc=%0d got=unchecked want=due_%0d",
                     sbq[0].name, cyc, sbq[0].due);
            void'(sbq.pop_front());
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
